// File: rtl/snake_engine.sv
// Snake game-state core: ring-buffer body, 8x8 occupancy grid, IDLE/RUN/DEAD control.
// Optional feature macro SNAKE_WALLS_EN: grid edges become lethal instead of wrapping.
module snake_engine #(
  parameter int MAX_LEN   = 16,
  parameter int START_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  logic [1:0] dir,
  input  logic       dir_valid,
  input  logic       grow,
  input  logic [2:0] row_addr,
  output logic [7:0] row_data,
  output logic [2:0] head_x,
  output logic [2:0] head_y,
  output logic [6:0] length,
  output logic       alive,
  output logic       dead
);

  localparam int PW = $clog2(MAX_LEN);
  localparam logic [7:0] START_MASK = 8'((9'd1 << START_LEN) - 9'd1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DEAD = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic [2:0]    hx_q, hx_d, hy_q, hy_d;
  logic [6:0]    len_q, len_d;
  logic [PW-1:0] head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d;
  logic [2:0]    body_x_q [MAX_LEN];
  logic [2:0]    body_x_d [MAX_LEN];
  logic [2:0]    body_y_q [MAX_LEN];
  logic [2:0]    body_y_d [MAX_LEN];
  logic [7:0]    grid_q [8];
  logic [7:0]    grid_d [8];
  logic          alive_q, alive_d, dead_q, dead_d;

  logic [1:0]    eff_dir_s;
  logic          dir_ok_s, vacate_s, hit_s, restart_s, advance_s, die_s;
  logic [2:0]    nx_s, ny_s, tail_x_s, tail_y_s;
  logic [PW-1:0] head_ptr_inc_s, tail_ptr_inc_s;

  assign row_data = grid_q[row_addr];
  assign head_x   = hx_q;
  assign head_y   = hy_q;
  assign length   = len_q;
  assign alive    = alive_q;
  assign dead     = dead_q;

  // Move decode: effective heading, candidate head cell and collision test
  always_comb begin
    dir_ok_s  = dir_valid && ((dir ^ 2'b10) != dir_q);
    eff_dir_s = dir_ok_s ? dir : dir_q;
    nx_s = hx_q;
    ny_s = hy_q;
    case (eff_dir_s)
      2'd0:    nx_s = hx_q + 3'd1;
      2'd1:    ny_s = hy_q - 3'd1;
      2'd2:    nx_s = hx_q - 3'd1;
      2'd3:    ny_s = hy_q + 3'd1;
      default: nx_s = hx_q;
    endcase
    tail_x_s = body_x_q[tail_ptr_q];
    tail_y_s = body_y_q[tail_ptr_q];
    vacate_s = !(grow && (len_q < 7'(MAX_LEN)));
    // Stepping into the tail cell is only legal when that cell is being vacated
    hit_s = grid_q[ny_s][nx_s] && !(vacate_s && (nx_s == tail_x_s) && (ny_s == tail_y_s));
`ifdef SNAKE_WALLS_EN
    if (((eff_dir_s == 2'd0) && (hx_q == 3'd7)) || ((eff_dir_s == 2'd1) && (hy_q == 3'd0)) ||
        ((eff_dir_s == 2'd2) && (hx_q == 3'd0)) || ((eff_dir_s == 2'd3) && (hy_q == 3'd7))) begin
      hit_s = 1'b1;
    end else begin
      hit_s = hit_s;
    end
`else
    hit_s = hit_s;
`endif
    restart_s = start && (state_q != S_RUN);
    advance_s = (state_q == S_RUN) && step && !hit_s;
    die_s     = (state_q == S_RUN) && step && hit_s;
    head_ptr_inc_s = (head_ptr_q == PW'(MAX_LEN - 1)) ? '0 : head_ptr_q + 1'b1;
    tail_ptr_inc_s = (tail_ptr_q == PW'(MAX_LEN - 1)) ? '0 : tail_ptr_q + 1'b1;
  end

  // Next-state: restart, direction load, advance or death
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    hx_d       = hx_q;
    hy_d       = hy_q;
    len_d      = len_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    body_x_d   = body_x_q;
    body_y_d   = body_y_q;
    grid_d     = grid_q;
    if (restart_s) begin
      state_d    = S_RUN;
      dir_d      = 2'd0;
      hx_d       = 3'(START_LEN - 1);
      hy_d       = 3'd0;
      len_d      = 7'(START_LEN);
      head_ptr_d = PW'(START_LEN - 1);
      tail_ptr_d = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        body_x_d[i] = (i < START_LEN) ? 3'(i) : 3'd0;
        body_y_d[i] = 3'd0;
      end
      for (int r = 0; r < 8; r++) begin
        grid_d[r] = (r == 0) ? START_MASK : 8'd0;
      end
    end else begin
      if (dir_ok_s) begin
        dir_d = dir;
      end else begin
        dir_d = dir_q;
      end
      if (die_s) begin
        state_d = S_DEAD;
      end else if (advance_s) begin
        hx_d       = nx_s;
        hy_d       = ny_s;
        head_ptr_d = head_ptr_inc_s;
        body_x_d[head_ptr_inc_s] = nx_s;
        body_y_d[head_ptr_inc_s] = ny_s;
        // Clear the tail before setting the head so a tail chase keeps the cell set
        if (vacate_s) begin
          grid_d[tail_y_s][tail_x_s] = 1'b0;
          tail_ptr_d = tail_ptr_inc_s;
        end else begin
          len_d = len_q + 7'd1;
        end
        grid_d[ny_s][nx_s] = 1'b1;
      end else begin
        state_d = state_q;
      end
    end
    alive_d = (state_d == S_RUN);
    dead_d  = die_s;
  end

  // State registers with asynchronous return to the reset game
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      dir_q      <= 2'd0;
      hx_q       <= 3'(START_LEN - 1);
      hy_q       <= 3'd0;
      len_q      <= 7'(START_LEN);
      head_ptr_q <= PW'(START_LEN - 1);
      tail_ptr_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        body_x_q[i] <= (i < START_LEN) ? 3'(i) : 3'd0;
        body_y_q[i] <= 3'd0;
      end
      for (int r = 0; r < 8; r++) begin
        grid_q[r] <= (r == 0) ? START_MASK : 8'd0;
      end
      alive_q <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      hx_q       <= hx_d;
      hy_q       <= hy_d;
      len_q      <= len_d;
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      body_x_q   <= body_x_d;
      body_y_q   <= body_y_d;
      grid_q     <= grid_d;
      alive_q    <= alive_d;
      dead_q     <= dead_d;
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Directed, table-driven bench for snake_engine plus a hand-written growth sequence.
module tb_snake_engine;

  logic       clk = 1'b0;
  logic       reset, start, step, dir_valid, grow;
  logic [1:0] dir;
  logic [2:0] row_addr;
  logic [7:0] row_data;
  logic [2:0] head_x, head_y;
  logic [6:0] length;
  logic       alive, dead;

  int n_pass  = 0;
  int n_total = 0;

  snake_engine dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .dir(dir),
    .dir_valid(dir_valid), .grow(grow), .row_addr(row_addr), .row_data(row_data),
    .head_x(head_x), .head_y(head_y), .length(length), .alive(alive), .dead(dead)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic       st, sp;
    logic [1:0] d;
    logic       dv, gr;
    logic [2:0] ra;
    logic [7:0] erow;
    logic [2:0] ex, ey;
    logic [6:0] elen;
    logic       eal, edd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int rst, input int st, input int sp, input int d, input int dv,
                     input int gr, input int ra, input int erow, input int ex, input int ey,
                     input int elen, input int eal, input int edd);
    vec_t v;
    v.rst = (rst != 0); v.st = 1'(st); v.sp = 1'(sp); v.d = 2'(d); v.dv = 1'(dv);
    v.gr = 1'(gr); v.ra = 3'(ra); v.erow = 8'(erow); v.ex = 3'(ex); v.ey = 3'(ey);
    v.elen = 7'(elen); v.eal = 1'(eal); v.edd = 1'(edd);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] erow, input logic [2:0] ex,
                       input logic [2:0] ey, input logic [6:0] elen, input logic eal,
                       input logic edd);
    n_total++;
    if ({row_data, head_x, head_y, length, alive, dead} === {erow, ex, ey, elen, eal, edd}) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got row=%b head=(%0d,%0d) len=%0d alive=%b dead=%b, want row=%b head=(%0d,%0d) len=%0d alive=%b dead=%b",
               name, row_data, head_x, head_y, length, alive, dead, erow, ex, ey, elen, eal, edd);
    end
  endtask

  initial begin
    logic [2:0] mx, my;
    logic [1:0] gd;
    int         elen, cnt;

    reset = 1'b0; start = 1'b0; step = 1'b0; dir = 2'd0; dir_valid = 1'b0; grow = 1'b0;
    row_addr = 3'd0;
    #12 reset = 1'b1;

    // A: reset, step ignored in IDLE, start, six steps right with wrap (or wall death)
    add(1,0,0,0,0,0, 0, 8'h07, 2,0,3, 0,0);
    add(0,0,1,0,0,0, 0, 8'h07, 2,0,3, 0,0);
    add(0,1,0,0,0,0, 0, 8'h07, 2,0,3, 1,0);
    add(0,0,1,0,0,0, 0, 8'h0E, 3,0,3, 1,0);
    add(0,0,1,0,0,0, 0, 8'h1C, 4,0,3, 1,0);
    add(0,0,1,0,0,0, 0, 8'h38, 5,0,3, 1,0);
    add(0,0,1,0,0,0, 0, 8'h70, 6,0,3, 1,0);
    add(0,0,1,0,0,0, 0, 8'hE0, 7,0,3, 1,0);
`ifdef SNAKE_WALLS_EN
    add(0,0,1,0,0,0, 0, 8'hE0, 7,0,3, 0,1);
    add(0,0,1,0,0,0, 0, 8'hE0, 7,0,3, 0,0);
    add(0,1,1,0,0,0, 0, 8'h07, 2,0,3, 1,0);
`else
    add(0,0,1,0,0,0, 0, 8'hC1, 0,0,3, 1,0);
    add(0,1,0,0,0,0, 0, 8'hC1, 0,0,3, 1,0);
`endif
    // B: start+step in IDLE drops the step; reversal ignored; dir_valid with step
    add(1,0,0,0,0,0, 0, 8'h07, 2,0,3, 0,0);
    add(0,1,1,0,0,0, 0, 8'h07, 2,0,3, 1,0);
    add(0,0,0,2,1,0, 0, 8'h07, 2,0,3, 1,0);
    add(0,0,1,0,0,0, 0, 8'h0E, 3,0,3, 1,0);
    add(0,1,0,0,0,0, 0, 8'h0E, 3,0,3, 1,0);
    add(0,0,1,3,1,0, 1, 8'h08, 3,1,3, 1,0);
    // D: self-collision, frozen grid, restart
    add(1,0,0,0,0,0, 0, 8'h07, 2,0,3, 0,0);
    add(0,1,0,0,0,0, 0, 8'h07, 2,0,3, 1,0);
    add(0,0,1,0,0,1, 0, 8'h0F, 3,0,4, 1,0);
    add(0,0,1,0,0,1, 0, 8'h1F, 4,0,5, 1,0);
    add(0,0,1,3,1,0, 0, 8'h1E, 4,1,5, 1,0);
    add(0,0,1,2,1,0, 1, 8'h18, 3,1,5, 1,0);
    add(0,0,1,1,1,0, 1, 8'h18, 3,1,5, 0,1);
    add(0,0,1,0,0,0, 0, 8'h1C, 3,1,5, 0,0);
    add(0,1,0,0,0,0, 0, 8'h07, 2,0,3, 1,0);
    // E: length-4 tail chase, then asynchronous reset mid-loop
    add(1,0,0,0,0,0, 0, 8'h07, 2,0,3, 0,0);
    add(0,1,0,0,0,0, 0, 8'h07, 2,0,3, 1,0);
    add(0,0,1,0,0,1, 0, 8'h0F, 3,0,4, 1,0);
    add(0,0,1,3,1,0, 1, 8'h08, 3,1,4, 1,0);
    add(0,0,1,2,1,0, 1, 8'h0C, 2,1,4, 1,0);
    add(0,0,1,1,1,0, 1, 8'h0C, 2,0,4, 1,0);
    add(0,0,1,0,1,0, 1, 8'h0C, 3,0,4, 1,0);
    add(0,0,1,3,1,0, 1, 8'h0C, 3,1,4, 1,0);
    add(0,0,1,2,1,0, 1, 8'h0C, 2,1,4, 1,0);
    add(0,0,1,1,1,0, 1, 8'h0C, 2,0,4, 1,0);
    add(0,0,1,0,1,0, 0, 8'h0C, 3,0,4, 1,0);
    add(1,0,0,0,0,0, 0, 8'h07, 2,0,3, 0,0);
    add(1,0,0,0,0,0, 1, 8'h00, 2,0,3, 0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      row_addr = tbl[i].ra;
      if (tbl[i].rst) begin
        reset = 1'b0;
        #1;
        check($sformatf("vec%0d", i), tbl[i].erow, tbl[i].ex, tbl[i].ey, tbl[i].elen,
              tbl[i].eal, tbl[i].edd);
        reset = 1'b1;
        #1;
      end else begin
        start = tbl[i].st; step = tbl[i].sp; dir = tbl[i].d;
        dir_valid = tbl[i].dv; grow = tbl[i].gr;
        @(posedge clk);
        #1;
        start = 1'b0; step = 1'b0; dir_valid = 1'b0; grow = 1'b0;
        check($sformatf("vec%0d", i), tbl[i].erow, tbl[i].ex, tbl[i].ey, tbl[i].elen,
              tbl[i].eal, tbl[i].edd);
      end
    end

    // Growth to MAX_LEN along a non-crossing path with grow held for 20 steps
    reset = 1'b0; #1; reset = 1'b1; #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mx = 3'd2; my = 3'd0;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 5)       gd = 2'd0;
      else if (k == 6)  gd = 2'd3;
      else if (k <= 13) gd = 2'd2;
      else if (k == 14) gd = 2'd3;
      else              gd = 2'd0;
      dir = gd; dir_valid = 1'b1; step = 1'b1; grow = 1'b1;
      @(posedge clk); #1;
      dir_valid = 1'b0; step = 1'b0; grow = 1'b0;
      case (gd)
        2'd0:    mx = mx + 3'd1;
        2'd1:    my = my - 3'd1;
        2'd2:    mx = mx - 3'd1;
        default: my = my + 3'd1;
      endcase
      elen = (3 + k > 16) ? 16 : 3 + k;
      n_total++;
      if ({head_x, head_y, length, alive} === {mx, my, 7'(elen), 1'b1}) begin
        n_pass++;
      end else begin
        $display("FAIL grow%0d: got head=(%0d,%0d) len=%0d alive=%b, want head=(%0d,%0d) len=%0d alive=1",
                 k, head_x, head_y, length, alive, mx, my, elen);
      end
    end
    cnt = 0;
    for (int r = 0; r < 8; r++) begin
      row_addr = 3'(r);
      #1;
      cnt += $countones(row_data);
    end
    n_total++;
    if (cnt == 16) begin
      n_pass++;
    end else begin
      $display("FAIL popcount: got %0d, want 16", cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
